// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the two requesters (ALU, RegFile), the TX
// scheduler and the UART TX.
//   alu_req/alu_data/alu_ack : ALU result request, 2*DATA_WIDTH word, ack pulse
//   reg_req/reg_data/reg_ack : RegFile read request, DATA_WIDTH byte, ack pulse
//   tx_busy                  : busy from the UART TX
//   tx_p_data/tx_data_valid  : byte and one-cycle strobe to the UART TX
//   sched_busy               : scheduler not idle
//   tx_err                   : one-cycle pulse when the UART never went busy
// Modports: slave = scheduler, master = requesters/UART side driving it.
interface uart_tx_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      alu_req;
  logic [2*DATA_WIDTH-1:0]   alu_data;
  logic                      alu_ack;
  logic                      reg_req;
  logic [DATA_WIDTH-1:0]     reg_data;
  logic                      reg_ack;
  logic                      tx_busy;
  logic [DATA_WIDTH-1:0]     tx_p_data;
  logic                      tx_data_valid;
  logic                      sched_busy;
  logic                      tx_err;

  modport slave (
    input  alu_req, alu_data, reg_req, reg_data, tx_busy,
    output alu_ack, reg_ack, tx_p_data, tx_data_valid, sched_busy, tx_err
  );

  modport master (
    output alu_req, alu_data, reg_req, reg_data, tx_busy,
    input  alu_ack, reg_ack, tx_p_data, tx_data_valid, sched_busy, tx_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares the single UART TX path between the ALU (2-byte result, low byte
// first) and the RegFile (1-byte read data). A granted word is captured,
// then sent byte by byte with a valid/busy handshake against the UART TX.
// A watchdog aborts the transfer if tx_busy never rises after a byte.
//
// Ports:
//   Clk  : system clock, all logic on posedge
//   RST  : asynchronous active-low reset
//   bus  : uart_tx_scheduler_if.slave (requests, acks, UART handshake,
//          sched_busy, tx_err); all outputs are registered.
// Parameters:
//   DATA_WIDTH   : UART byte width (ALU word is 2*DATA_WIDTH)
//   BUSY_TIMEOUT : WAIT_HI cycles allowed for tx_busy to rise
// Configuration:
//   TX_SCHED_RR_EN defined   : round-robin arbitration on simultaneous
//                              requests (last grant loses the next tie;
//                              flag resets to REG so ALU wins first tie).
//   TX_SCHED_RR_EN undefined : fixed priority, ALU over REG.
module uart_tx_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input logic               Clk,
  input logic               RST,
  uart_tx_scheduler_if.slave bus
);

  localparam int unsigned WD_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t                  state;
  // Only the byte still to be sent after the first one is kept; the first
  // byte goes straight into the output register at the grant edge.
  logic [DATA_WIDTH-1:0]   hold_hi;
  logic [1:0]              bytes_left;
  logic [WD_W-1:0]         wd_cnt;
  logic [WD_W-1:0]         wd_next;

  logic                    alu_ack_q;
  logic                    reg_ack_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   pdata_q;

  logic                    grant_alu;
  logic                    grant_reg;

`ifdef TX_SCHED_RR_EN
  // 1: ALU was granted last, 0: REG was granted last.
  logic                    last_alu;
`endif

  // Grant only from IDLE and only while the UART is not busy.
  always_comb begin
    grant_alu = 1'b0;
    grant_reg = 1'b0;
    if (state == IDLE && !bus.tx_busy) begin
`ifdef TX_SCHED_RR_EN
      if (bus.alu_req && bus.reg_req) begin
        grant_alu = !last_alu;
        grant_reg = last_alu;
      end else begin
        grant_alu = bus.alu_req;
        grant_reg = bus.reg_req;
      end
`else
      grant_alu = bus.alu_req;
      grant_reg = bus.reg_req && !bus.alu_req;
`endif
    end
  end

  // Saturating watchdog increment.
  always_comb begin
    wd_next = wd_cnt;
    if (wd_cnt != WD_W'(BUSY_TIMEOUT)) begin
      wd_next = wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      hold_hi    <= '0;
      bytes_left <= '0;
      wd_cnt     <= '0;
      alu_ack_q  <= 1'b0;
      reg_ack_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      pdata_q    <= '0;
`ifdef TX_SCHED_RR_EN
      last_alu   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      alu_ack_q <= 1'b0;
      reg_ack_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_alu || grant_reg) begin
            // First byte, ack and valid are all loaded on the grant edge so
            // that ack and the first valid appear together in SEND.
            if (grant_alu) begin
              hold_hi    <= bus.alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
              pdata_q    <= bus.alu_data[DATA_WIDTH-1:0];
              bytes_left <= 2'd2;
              alu_ack_q  <= 1'b1;
            end else begin
              hold_hi    <= '0;
              pdata_q    <= bus.reg_data;
              bytes_left <= 2'd1;
              reg_ack_q  <= 1'b1;
            end
`ifdef TX_SCHED_RR_EN
            last_alu <= grant_alu;
`endif
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SEND;
          end
        end

        SEND: begin
          wd_cnt <= '0;
          state  <= WAIT_HI;
        end

        WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= WAIT_LO;
          end else begin
            wd_cnt <= wd_next;
            if (wd_next == WD_W'(BUSY_TIMEOUT)) begin
              // UART never started: drop whatever is left of the word.
              err_q      <= 1'b1;
              bytes_left <= '0;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (bytes_left > 2'd1) begin
              bytes_left <= bytes_left - 2'd1;
              pdata_q    <= hold_hi;
              valid_q    <= 1'b1;
              state      <= SEND;
            end else begin
              bytes_left <= '0;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_ack       = alu_ack_q;
  assign bus.reg_ack       = reg_ack_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.tx_p_data     = pdata_q;
  assign bus.sched_busy    = busy_q;
  assign bus.tx_err        = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: scoreboard of expected grant owners and
// transmitted bytes, a simple UART TX busy model, and directed scenarios.
module tb_uart_tx_scheduler;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  logic Clk = 1'b0;
  logic RST = 1'b0;
  always #5 Clk = ~Clk;

  uart_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_scheduler #(
    .DATA_WIDTH  (DW),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .Clk(Clk),
    .RST(RST),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard queues: owner 0 = ALU, 1 = REG.
  logic [7:0] exp_bytes[$];
  int         exp_acks[$];
  int n_valid = 0, n_alu_ack = 0, n_reg_ack = 0, n_err = 0;
  int last_valid_cyc = 0;

  always @(negedge Clk) begin
    if (RST) begin
      if (bus.tx_data_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        check("valid_expected", (exp_bytes.size() != 0), 1);
        if (exp_bytes.size() != 0) check("tx_byte", bus.tx_p_data, exp_bytes.pop_front());
      end
      if (bus.alu_ack || bus.reg_ack) begin
        check("single_ack", (bus.alu_ack && bus.reg_ack), 0);
        check("ack_with_valid", bus.tx_data_valid, 1);
        check("ack_expected", (exp_acks.size() != 0), 1);
        if (exp_acks.size() != 0) check("ack_owner", bus.reg_ack ? 1 : 0, exp_acks.pop_front());
        if (bus.alu_ack) n_alu_ack++;
        if (bus.reg_ack) n_reg_ack++;
      end
      if (bus.tx_err) n_err++;
    end
  end

  // UART TX model: busy rises one cycle after a valid, stays high 11 cycles.
  bit model_en = 1'b1;
  bit ext_busy = 1'b0;
  int mcnt = 0;
  bit pend = 1'b0;
  bit prev_busy = 1'b0;
  int fall_cnt = 0;
  int last_fall_cyc = 0;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (!RST) begin
        mcnt = 0;
        pend = 1'b0;
      end else begin
        if (mcnt > 0) mcnt--;
        if (pend) begin
          pend = 1'b0;
          mcnt = 11;
        end
        if (bus.tx_data_valid && model_en) pend = 1'b1;
      end
      bus.tx_busy = ext_busy || (mcnt > 0);
      if (prev_busy && !bus.tx_busy) begin
        fall_cnt++;
        last_fall_cyc = cyc;
      end
      prev_busy = bus.tx_busy;
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic request(input bit is_reg, input int n, input logic [15:0] d0, input logic [15:0] d1);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (is_reg) begin
        bus.reg_data = (i == 0) ? d0[7:0] : d1[7:0];
        bus.reg_req  = 1'b1;
      end else begin
        bus.alu_data = (i == 0) ? d0 : d1;
        bus.alu_req  = 1'b1;
      end
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
        tick();
        if (is_reg ? bus.reg_ack : bus.alu_ack) ok = 1'b1;
      end
      // Drop in the ack cycle so req is low at the edge after ack.
      if (is_reg) bus.reg_req = 1'b0;
      else        bus.alu_req = 1'b0;
      check(is_reg ? "reg_ack_seen" : "alu_ack_seen", ok, 1);
      tick();
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (!bus.sched_busy && !bus.tx_busy) done = 1'b1;
    end
    check("idle_reached", done, 1);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_alu_ack"}, bus.alu_ack, 0);
    check({tag, "_reg_ack"}, bus.reg_ack, 0);
    check({tag, "_valid"},   bus.tx_data_valid, 0);
    check({tag, "_pdata"},   bus.tx_p_data, 0);
    check({tag, "_sbusy"},   bus.sched_busy, 0);
    check({tag, "_err"},     bus.tx_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base_v, base_a, base_r, f0, s_cyc;
    bit ok;
    bus.alu_req  = 1'b0;
    bus.alu_data = '0;
    bus.reg_req  = 1'b0;
    bus.reg_data = '0;

    // Reset state
    repeat (3) tick();
    check_outputs_zero("in_reset");
    RST = 1'b1;
    tick();
    check_outputs_zero("after_reset");

    // Simultaneous held requests, right after reset (RR flag at REG).
`ifdef TX_SCHED_RR_EN
    exp_acks.push_back(0); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
    exp_acks.push_back(1); exp_bytes.push_back(8'hA1);
    exp_acks.push_back(0); exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'hBE);
    exp_acks.push_back(1); exp_bytes.push_back(8'hA2);
`else
    exp_acks.push_back(0); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
    exp_acks.push_back(0); exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'hBE);
    exp_acks.push_back(1); exp_bytes.push_back(8'hA1);
    exp_acks.push_back(1); exp_bytes.push_back(8'hA2);
`endif
    fork
      request(1'b0, 2, 16'h1234, 16'hBEEF);
      request(1'b1, 2, 16'h00A1, 16'h00A2);
    join
    wait_idle();
    check("tie_acks_left", exp_acks.size(), 0);
    check("tie_bytes_left", exp_bytes.size(), 0);

    // Single REG byte
    base_v = n_valid; base_r = n_reg_ack;
    exp_acks.push_back(1); exp_bytes.push_back(8'hA5);
    f0 = fall_cnt;
    request(1'b1, 1, 16'h00A5, 16'h0000);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      if (fall_cnt != f0) ok = 1'b1;
    end
    check("reg_busy_fall", ok, 1);
    check("reg_sbusy_at_fall", bus.sched_busy, 1);
    tick();
    check("reg_sbusy_after_fall", bus.sched_busy, 0);
    repeat (3) tick();
    check("reg_valid_count", n_valid - base_v, 1);
    check("reg_ack_count", n_reg_ack - base_r, 1);

    // ALU word, low byte first
    base_v = n_valid; base_a = n_alu_ack;
    exp_acks.push_back(0); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
    request(1'b0, 1, 16'h1234, 16'h0000);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      if (n_valid - base_v == 2) ok = 1'b1;
    end
    check("alu_second_valid", ok, 1);
    // Valid lands in the second cycle with tx_busy low.
    check("alu_byte_gap", last_valid_cyc - last_fall_cyc, 1);
    wait_idle();
    check("alu_ack_count", n_alu_ack - base_a, 1);
    check("alu_valid_count", n_valid - base_v, 2);

    // Watchdog: UART never goes busy
    model_en = 1'b0;
    base_v = n_valid;
    exp_acks.push_back(0); exp_bytes.push_back(8'hFE);
    bus.alu_data = 16'hCAFE;
    bus.alu_req  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (bus.alu_ack) ok = 1'b1;
    end
    bus.alu_req = 1'b0;
    check("wd_ack_seen", ok, 1);
    s_cyc = cyc;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (bus.tx_err) ok = 1'b1;
    end
    check("wd_err_seen", ok, 1);
    check("wd_err_delay", cyc - s_cyc, TO + 1);
    check("wd_sbusy_idle", bus.sched_busy, 0);
    tick();
    check("wd_err_pulse_width", bus.tx_err, 0);
    repeat (10) tick();
    check("wd_no_high_byte", n_valid - base_v, 1);
    check("wd_err_count", n_err, 1);
    model_en = 1'b1;
    exp_acks.push_back(1); exp_bytes.push_back(8'h3C);
    request(1'b1, 1, 16'h003C, 16'h0000);
    wait_idle();

    // External busy in IDLE blocks the grant
    ext_busy = 1'b1;
    repeat (2) tick();
    base_r = n_reg_ack;
    exp_acks.push_back(1); exp_bytes.push_back(8'hC3);
    bus.reg_data = 8'hC3;
    bus.reg_req  = 1'b1;
    repeat (6) tick();
    check("blocked_no_ack", n_reg_ack - base_r, 0);
    check("blocked_sbusy", bus.sched_busy, 0);
    f0 = fall_cnt;
    ext_busy = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (bus.reg_ack) ok = 1'b1;
    end
    bus.reg_req = 1'b0;
    check("unblocked_ack", ok, 1);
    check("unblocked_fall_seen", fall_cnt - f0, 1);
    check("unblocked_latency", cyc - last_fall_cyc, 1);
    wait_idle();

    // Reset during WAIT_LO of the ALU low byte
    base_v = n_valid;
    exp_acks.push_back(0); exp_bytes.push_back(8'h78); exp_bytes.push_back(8'h56);
    request(1'b0, 1, 16'h5678, 16'h0000);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.tx_busy) ok = 1'b1;
      else tick();
    end
    check("rst_busy_high", ok, 1);
    repeat (2) tick();
    check("rst_pre_sbusy", bus.sched_busy, 1);
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_bytes.delete();
    repeat (2) tick();
    RST = 1'b1;
    repeat (20) tick();
    check("rst_no_high_byte", n_valid - base_v, 1);
    exp_acks.push_back(1); exp_bytes.push_back(8'h99);
    request(1'b1, 1, 16'h0099, 16'h0000);
    wait_idle();
    check("rst_fresh_valid", n_valid - base_v, 2);

    check("final_acks_left", exp_acks.size(), 0);
    check("final_bytes_left", exp_bytes.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
